// File: rtl/column_serial_multiplier.sv
// Column-serial unsigned WIDTH x WIDTH multiplier.
// One product column is resolved per cycle: the column's partial-product bits
// are counted, added to the carry count from the previous column, the sum LSB
// becomes product bit k and the remaining bits carry into column k+1.
// Sequential reference datapath for the compressor-tree multipliers.
module column_serial_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    // Product width, column-index width and carry/sum width.
    localparam int PW   = 2 * WIDTH;
    localparam int COLW = $clog2(PW);
    localparam int CW   = $clog2(2 * WIDTH + 1);

    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [COLW-1:0] COL_ZERO = {COLW{1'b0}};
    localparam logic [COLW-1:0] COL_ONE  = {{(COLW-1){1'b0}}, 1'b1};
    localparam logic [COLW-1:0] COL_LAST = COLW'(PW - 1);
    localparam logic [PW-1:0]   PROD_ZERO = {PW{1'b0}};
    localparam logic [WIDTH-1:0] OPND_ZERO = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [COLW-1:0]   col_q;
    logic [CW-1:0]     carry_q;
    logic [PW-1:0]     product_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [CW-1:0]     cnt_s;
    logic [CW-1:0]     sum_d;

    // Bit-heap height of column k: number of pairs (i,j) with i+j==k and
    // a[i]&b[j]. Columns k >= WIDTH of the upper half naturally shrink and
    // the unused top column (k = 2*WIDTH-1) always counts zero.
    function automatic logic [CW-1:0] column_count(
        input logic [WIDTH-1:0] av,
        input logic [WIDTH-1:0] bv,
        input logic [COLW-1:0]  k
    );
        logic [CW-1:0] cnt;
        cnt = CNT_ZERO;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (((i + j) == int'(k)) && av[i] && bv[j]) begin
                    cnt = cnt + CNT_ONE;
                end else begin
                    cnt = cnt;
                end
            end
        end
        return cnt;
    endfunction

    // Column datapath: count the current column and add the incoming carry.
    always_comb begin
        cnt_s = column_count(a_q, b_q, col_q);
        sum_d = cnt_s + carry_q;
    end

    // Control FSM with registered handshake outputs and the column datapath state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= OPND_ZERO;
            b_q         <= OPND_ZERO;
            col_q       <= COL_ZERO;
            carry_q     <= CNT_ZERO;
            product_q   <= PROD_ZERO;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        col_q      <= COL_ZERO;
                        carry_q    <= CNT_ZERO;
                        product_q  <= PROD_ZERO;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_RUN;
                    end else begin
                        state_q    <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    product_q[col_q] <= sum_d[0];
                    carry_q          <= {1'b0, sum_d[CW-1:1]};
                    if (col_q == COL_LAST) begin
                        // Last column resolved: present the product next cycle.
                        col_q       <= COL_ZERO;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        col_q       <= col_q + COL_ONE;
                        state_q     <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        // Product is kept; it is only cleared on the next accept.
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        state_q     <= ST_DONE;
                    end
                end
                default: begin
                    col_q       <= COL_ZERO;
                    carry_q     <= CNT_ZERO;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_column_serial_multiplier.sv
// Directed bench for column_serial_multiplier at WIDTH=4 and WIDTH=8.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_column_serial_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    // Free-running cycle counter used to measure accept-to-accept spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH=4 instance signals
    logic       rst4, iv4, ir4, ov4, or4, busy4;
    logic [3:0] a4, b4;
    logic [7:0] p4;
    // WIDTH=8 instance signals
    logic        rst8, iv8, ir8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    column_serial_multiplier #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst4), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .out_valid(ov4), .out_ready(or4), .product(p4), .busy(busy4)
    );

    column_serial_multiplier #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Launch one WIDTH=4 operation from IDLE and wait for out_valid.
    // lat is the index of the cycle in which out_valid is first seen, where
    // the cycle that begins at the accept edge is cycle 1.
    task automatic do_op4(input logic [3:0] av, input logic [3:0] bv,
                          output logic [7:0] pv, output int lat);
        a4 = av; b4 = bv; iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        lat = 1;
        while (!ov4 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        pv = p4;
        check("carry_at_done", 64'(u4.carry_q), 64'd0);
    endtask

    initial begin
        logic [7:0] pv;
        int lat;
        int ov_seen;
        int last_acc;
        int err_before;
        int w;
        logic [7:0] ra, rb;

        vecs[0] = '{4'd0,  4'd0,  8'h00};
        vecs[1] = '{4'd15, 4'd15, 8'hE1};
        vecs[2] = '{4'd13, 4'd11, 8'h8F};
        vecs[3] = '{4'd1,  4'd1,  8'h01};
        vecs[4] = '{4'd15, 4'd1,  8'h0F};
        vecs[5] = '{4'd8,  4'd8,  8'h40};
        vecs[6] = '{4'd5,  4'd10, 8'h32};
        vecs[7] = '{4'd0,  4'd15, 8'h00};
        vecs[8] = '{4'd7,  4'd6,  8'h2A};

        rst4 = 1'b1; iv4 = 1'b0; a4 = 4'd0; b4 = 4'd0; or4 = 1'b1;
        rst8 = 1'b1; iv8 = 1'b0; a8 = 8'd0; b8 = 8'd0; or8 = 1'b1;
        repeat (2) @(negedge clk);
        rst4 = 1'b0; rst8 = 1'b0;

        // 1. reset state
        check("rst_in_ready",  ir4,   1);
        check("rst_out_valid", ov4,   0);
        check("rst_product",   p4,    0);
        check("rst_busy",      busy4, 0);
        check("rst8_in_ready", ir8,   1);
        check("rst8_product",  p8,    0);

        // 2/3. table of directed products, out_ready held high
        for (int i = 0; i < 9; i++) begin
            do_op4(vecs[i].a, vecs[i].b, pv, lat);
            check("tbl_product", pv, vecs[i].p);
            check("tbl_latency", lat, 9);
            check("tbl_busy_done", busy4, 1);
            @(negedge clk);
            check("tbl_ov_one_cycle", ov4, 0);
            check("tbl_in_ready_back", ir4, 1);
        end

        // 4. out_ready low holds the product; in_valid during RUN/DONE ignored
        or4 = 1'b0; a4 = 4'd9; b4 = 4'd7; iv4 = 1'b1;
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd3;
        lat = 1;
        while (!ov4 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("hold_latency", lat, 9);
        check("hold_product", p4, 8'h3F);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_ov", ov4, 1);
            check("hold_prod", p4, 8'h3F);
            check("hold_in_ready", ir4, 0);
        end
        or4 = 1'b1; iv4 = 1'b0;
        @(negedge clk);
        check("release_in_ready", ir4, 1);
        check("release_ov", ov4, 0);
        check("release_busy", busy4, 0);
        check("release_prod_kept", p4, 8'h3F);

        // 5. reset in the 3rd RUN cycle discards the operation
        a4 = 4'd12; b4 = 4'd12; iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        check("midrun_rst_in_ready", ir4, 1);
        check("midrun_rst_busy", busy4, 0);
        check("midrun_rst_product", p4, 0);
        ov_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (ov4) ov_seen++;
            @(negedge clk);
        end
        check("midrun_rst_no_ov", ov_seen, 0);

        // 6a. exhaustive WIDTH=4 with in_valid held high (back-to-back)
        err_before = n_err;
        last_acc = 0;
        iv4 = 1'b1;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                w = 0;
                while (!ir4 && w < 60) begin
                    @(negedge clk);
                    w++;
                end
                a4 = 4'(x); b4 = 4'(y);
                @(negedge clk);
                if (x != 0 || y != 0) check("throughput4", cyc - last_acc, 10);
                last_acc = cyc;
                lat = 1;
                while (!ov4 && lat < 60) begin
                    @(negedge clk);
                    lat++;
                end
                check("exh4_latency", lat, 9);
                check("exh4_product", p4, x * y);
            end
        end
        iv4 = 1'b0;

        // 6b. 1000 WIDTH=8 pairs (two directed corners then random), back-to-back
        iv8 = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            if (n == 0) begin
                ra = 8'd255; rb = 8'd255;
            end else if (n == 1) begin
                ra = 8'd0; rb = 8'd200;
            end else begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
            end
            w = 0;
            while (!ir8 && w < 80) begin
                @(negedge clk);
                w++;
            end
            a8 = ra; b8 = rb;
            @(negedge clk);
            lat = 1;
            while (!ov8 && lat < 80) begin
                @(negedge clk);
                lat++;
            end
            check("rnd8_latency", lat, 17);
            check("rnd8_product", p8, 32'(ra) * 32'(rb));
        end
        iv8 = 1'b0;

        if (n_err == err_before) $display("Test passed.");
        else $display("Test failed.");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
